// File: rtl/riscv_lsu_iface_if.sv
// Bus bundle between a RISC-V core's load/store unit and a word-wide memory.
// It also defines the shared access-size codes (RISC-V funct3 encoding).
//   slave  modport: the LSU interface block (takes CPU requests and read data,
//                   drives ready/result/misaligned and the memory beat signals)
//   master modport: the requester side (core plus memory model)
`ifndef RISCV_LSU_SIZE_CODES
`define RISCV_LSU_SIZE_CODES
`define MASK_B  3'b000
`define MASK_H  3'b001
`define MASK_W  3'b010
`define MASK_BU 3'b100
`define MASK_HU 3'b101
`endif

interface riscv_lsu_iface_if;
  logic        cpu_req_in;
  logic        cpu_write_in;
  logic [31:0] cpu_addr_in;
  logic [31:0] cpu_data_in;
  logic [2:0]  cpu_size_in;
  logic        cpu_ready_out;
  logic [31:0] cpu_data_out;
  logic        cpu_valid_out;
  logic        cpu_misaligned_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_write_enable;
  logic [31:0] mem_data_in;

  modport slave (
    input  cpu_req_in, cpu_write_in, cpu_addr_in, cpu_data_in, cpu_size_in, mem_data_in,
    output cpu_ready_out, cpu_data_out, cpu_valid_out, cpu_misaligned_out,
           mem_addr_out, mem_data_out, mem_write_enable
  );

  modport master (
    output cpu_req_in, cpu_write_in, cpu_addr_in, cpu_data_in, cpu_size_in, mem_data_in,
    input  cpu_ready_out, cpu_data_out, cpu_valid_out, cpu_misaligned_out,
           mem_addr_out, mem_data_out, mem_write_enable
  );
endinterface

// File: rtl/riscv_lsu_iface.sv
// Load/store interface between a RISC-V core and a 32-bit word memory.
// Aligns byte/halfword/word accesses onto byte lanes, splits word-crossing
// accesses into two beats (or rejects them when ALLOW_MISALIGNED=0), and
// tracks outstanding loads to merge and extend the returned data.
// Ports:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   bus     - riscv_lsu_iface_if.slave (CPU request/response + memory beats)
//
// state | meaning
// IDLE  | ready for a request; single-beat and first beats issue here
// BEAT2 | issuing the second word of a crossing access; requests ignored
module riscv_lsu_iface #(
  parameter int READ_LATENCY     = 2,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic clk_in,
  input logic rst_in,
  riscv_lsu_iface_if.slave bus
);

  typedef enum logic {IDLE, BEAT2} state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] size;
    logic [1:0] offset;
    logic       crossing;
    logic       beat;
  } trk_t;

  state_t      state, state_nxt;
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic        legal, crossing, ready, accept, issue;
  logic [3:0]  base_mask;
  logic [7:0]  lane_wide;
  logic [63:0] data_wide;

  logic [29:0] b2_addr;
  logic [3:0]  b2_we;
  logic [31:0] b2_data;
  logic        b2_write;
  logic [2:0]  b2_size;
  logic [1:0]  b2_off;

  trk_t        trk [READ_LATENCY];
  trk_t        trk_in, tail;
  logic [31:0] hold;
  logic        mis_q;
  logic [63:0] raw;
  logic [31:0] load_word, ext;
  logic        valid;

  // Request decode. Lane mask and data are shifted into a double-word so the
  // low half is beat 1 and the high half is what spills into the next word.
  always_comb begin
    off    = bus.cpu_addr_in[1:0];
    legal  = 1'b1;
    nbytes = 3'd0;
    case (bus.cpu_size_in)
      `MASK_B, `MASK_BU: nbytes = 3'd1;
      `MASK_H, `MASK_HU: nbytes = 3'd2;
      `MASK_W:           nbytes = 3'd4;
      default:           legal  = 1'b0;
    endcase
    crossing = ({1'b0, off} + nbytes) > 3'd4;
    case (nbytes)
      3'd1:    base_mask = 4'b0001;
      3'd2:    base_mask = 4'b0011;
      3'd4:    base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    lane_wide = {4'b0000, base_mask} << off;
    data_wide = {32'h0, bus.cpu_data_in} << {off, 3'b000};
    ready     = (state == IDLE) && !rst_in;
    accept    = bus.cpu_req_in && ready;
    issue     = accept && (!crossing || ALLOW_MISALIGNED);
  end

  always_comb begin
    state_nxt            = state;
    bus.mem_addr_out     = {2'b00, bus.cpu_addr_in[31:2]};
    bus.mem_write_enable = 4'b0000;
    bus.mem_data_out     = 32'h0;
    trk_in               = '0;
    case (state)
      IDLE: begin
        if (issue) begin
          if (bus.cpu_write_in) begin
            if (legal) begin
              bus.mem_write_enable = lane_wide[3:0];
              bus.mem_data_out     = data_wide[31:0];
            end
          end else begin
            trk_in.valid    = 1'b1;
            trk_in.size     = bus.cpu_size_in;
            trk_in.offset   = off;
            trk_in.crossing = crossing;
            trk_in.beat     = 1'b0;
          end
          if (crossing) state_nxt = BEAT2;
        end
      end
      BEAT2: begin
        bus.mem_addr_out = {2'b00, b2_addr};
        if (b2_write) begin
          bus.mem_write_enable = b2_we;
          bus.mem_data_out     = b2_data;
        end else begin
          trk_in.valid    = 1'b1;
          trk_in.size     = b2_size;
          trk_in.offset   = b2_off;
          trk_in.crossing = 1'b1;
          trk_in.beat     = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset aborts whatever beat is in flight, including a pending BEAT2.
    if (rst_in) begin
      bus.mem_write_enable = 4'b0000;
      bus.mem_data_out     = 32'h0;
      trk_in               = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      mis_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) trk[i] <= '0;
    end else begin
      state  <= state_nxt;
      mis_q  <= accept && crossing && !ALLOW_MISALIGNED;
      trk[0] <= trk_in;
      for (int i = 1; i < READ_LATENCY; i++) trk[i] <= trk[i-1];
    end
  end

  // Datapath holding registers; only consumed when qualified by state/tracking.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && issue) begin
      b2_addr  <= bus.cpu_addr_in[31:2] + 30'd1;
      b2_we    <= lane_wide[7:4];
      b2_data  <= data_wide[63:32];
      b2_write <= bus.cpu_write_in && legal;
      b2_size  <= bus.cpu_size_in;
      b2_off   <= off;
    end
    if (tail.valid && tail.crossing && !tail.beat) hold <= bus.mem_data_in;
  end

  // Load return: a crossing load pairs the captured first word (low) with the
  // second word (high) before shifting the selected bytes down to bit 0.
  always_comb begin
    tail      = trk[READ_LATENCY-1];
    raw       = tail.crossing ? {bus.mem_data_in, hold} : {32'h0, bus.mem_data_in};
    load_word = 32'(raw >> {tail.offset, 3'b000});
    valid     = tail.valid && !(tail.crossing && !tail.beat) && !rst_in;
    case (tail.size)
      `MASK_B:  ext = {{24{load_word[7]}}, load_word[7:0]};
      `MASK_BU: ext = {24'h0, load_word[7:0]};
      `MASK_H:  ext = {{16{load_word[15]}}, load_word[15:0]};
      `MASK_HU: ext = {16'h0, load_word[15:0]};
      `MASK_W:  ext = load_word;
      default:  ext = 32'h0;
    endcase
    bus.cpu_valid_out      = valid;
    bus.cpu_data_out       = valid ? ext : 32'h0;
    bus.cpu_misaligned_out = mis_q && !rst_in;
    bus.cpu_ready_out      = ready;
  end

endmodule
